// File: rtl/rip_csr_trap_unit_pkg.sv
// Shared types, CSR addresses and helpers for the RIP machine-mode CSR/trap unit.
package rip_csr_trap_unit_pkg;

    typedef enum logic [1:0] {
        CsrRead = 2'd0,
        CsrRw   = 2'd1,
        CsrRs   = 2'd2,
        CsrRc   = 2'd3
    } csr_op_e;

    typedef enum logic {
        StIdle  = 1'b0,
        StRedir = 1'b1
    } trap_state_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam logic [4:0] CAUSE_BREAKPOINT = 5'd3;
    localparam logic [4:0] CAUSE_MEXT_INT   = 5'd11;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MIE_MEIE     = 11;

    // Read-modify-write result of a CSR instruction.
    function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] old_val,
                                              logic [31:0] wdata);
        logic [31:0] res;
        case (op)
            CsrRw:   res = wdata;
            CsrRs:   res = old_val | wdata;
            CsrRc:   res = old_val & ~wdata;
            default: res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rip_csr_counter.sv
// Performance counter with increment enable and independent low/high half writes.
module rip_csr_counter #(
    parameter int unsigned CNT_WIDTH = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [63:0]          cur, nxt;

    // A half write wins over the increment; carry into the high half is implicit in the add.
    always_comb begin
        cur = '0;
        cur[CNT_WIDTH-1:0] = cnt_q;
        nxt = cur;
        if (wr_lo_i) begin
            nxt[31:0] = wdata_i;
        end else if (wr_hi_i) begin
            nxt[63:32] = wdata_i;
        end else if (inc_i) begin
            nxt = cur + 64'd1;
        end
        cnt_d = nxt[CNT_WIDTH-1:0];
    end

    assign value_o = cur;

    // Counter state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rip_csr_trap_unit.sv
// Machine-mode CSR file and trap/mret sequencer issuing one PC redirect per event.
module rip_csr_trap_unit
    import rip_csr_trap_unit_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int unsigned CNT_WIDTH   = 64,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            csr_valid,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            exc_valid,
    input  logic [4:0]      exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret,
    input  logic            retire,
    input  logic            irq_ext,
    input  logic [XLEN-1:0] irq_pc,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    // mtvec.MODE bit 1 is reserved; bit 0 only exists when vectoring is supported.
    function automatic logic [XLEN-1:0] mtvec_warl(logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r    = v;
        r[1] = 1'b0;
        if (!VECTORED_EN) r[0] = 1'b0;
        return r;
    endfunction

    localparam logic [XLEN-1:0] PcMask = ~XLEN'(3);

    csr_op_e         op;
    logic            mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
    logic            meie_q, meie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d, mscratch_q, mscratch_d;
    trap_state_e     state_q;
    logic            redirect_q, busy_q;
    logic [XLEN-1:0] redirect_pc_q;

    logic            csr_known, wr_intent, csr_we;
    logic            exc_take, irq_take, trap_take, mret_take;
    logic [XLEN-1:0] csr_new, trap_target;
    logic [63:0]     mcycle_val, minstret_val;

    assign op = csr_op_e'(csr_op);

    // Old-value read mux and address decode.
    always_comb begin
        csr_known = 1'b1;
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS:   csr_rdata = {19'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
            CSR_MIE:       csr_rdata = {20'b0, meie_q, 11'b0};
            CSR_MTVEC:     csr_rdata = mtvec_q;
            CSR_MSCRATCH:  csr_rdata = mscratch_q;
            CSR_MEPC:      csr_rdata = mepc_q;
            CSR_MCAUSE:    csr_rdata = mcause_q;
            CSR_MTVAL:     csr_rdata = mtval_q;
            CSR_MIP:       csr_rdata = {20'b0, irq_ext, 11'b0};
            CSR_MCYCLE:    csr_rdata = mcycle_val[31:0];
            CSR_MCYCLEH:   csr_rdata = mcycle_val[63:32];
            CSR_MINSTRET:  csr_rdata = minstret_val[31:0];
            CSR_MINSTRETH: csr_rdata = minstret_val[63:32];
            default:       csr_known = 1'b0;
        endcase
    end

    // RS/RC with a zero operand never writes, so they stay legal on read-only mip.
    assign wr_intent   = (op == CsrRw) || ((op != CsrRead) && (csr_wdata != '0));
    assign csr_illegal = !csr_known || ((csr_addr == CSR_MIP) && wr_intent);
    assign csr_new     = csr_apply(op, csr_rdata, csr_wdata);

    assign exc_take  = exc_valid && !busy_q;
    assign irq_take  = irq_ext && mst_mie_q && meie_q && !busy_q;
    assign trap_take = exc_take || irq_take;
    assign mret_take = mret && !busy_q && !trap_take;
    assign csr_we    = csr_valid && wr_intent && !csr_illegal && !busy_q && !trap_take
                       && !mret_take;

    // Trap target: aligned base, plus 4*cause for vectored interrupts.
    always_comb begin
        trap_target = {mtvec_q[XLEN-1:2], 2'b00};
        if (!exc_take && VECTORED_EN && mtvec_q[0]) begin
            trap_target = trap_target + {{(XLEN-7){1'b0}}, CAUSE_MEXT_INT, 2'b00};
        end
    end

    // Next-state for CSRs: trap beats mret beats a CSR write.
    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        meie_d     = meie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mscratch_d = mscratch_q;
        if (trap_take) begin
            mepc_d     = (exc_take ? exc_pc : irq_pc) & PcMask;
            mcause_d   = exc_take ? {1'b0, {(XLEN-6){1'b0}}, exc_cause}
                                  : {1'b1, {(XLEN-6){1'b0}}, CAUSE_MEXT_INT};
            mtval_d    = exc_take ? exc_tval : '0;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end else if (mret_take) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end else if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mst_mie_d  = csr_new[MSTATUS_MIE];
                    mst_mpie_d = csr_new[MSTATUS_MPIE];
                end
                CSR_MIE:      meie_d     = csr_new[MIE_MEIE];
                CSR_MTVEC:    mtvec_d    = mtvec_warl(csr_new);
                CSR_MSCRATCH: mscratch_d = csr_new;
                CSR_MEPC:     mepc_d     = csr_new & PcMask;
                CSR_MCAUSE:   mcause_d   = csr_new;
                CSR_MTVAL:    mtval_d    = csr_new;
                default: ;
            endcase
        end
    end

    // CSR state registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            meie_q     <= 1'b0;
            mtvec_q    <= mtvec_warl(MTVEC_RESET);
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mscratch_q <= '0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            meie_q     <= meie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mscratch_q <= mscratch_d;
        end
    end

    // Redirect sequencer: one REDIR cycle per trap or mret, outputs registered.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= StIdle;
            redirect_q    <= 1'b0;
            busy_q        <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (trap_take || mret_take) begin
                        state_q       <= StRedir;
                        redirect_q    <= 1'b1;
                        busy_q        <= 1'b1;
                        redirect_pc_q <= trap_take ? trap_target : mepc_q;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    redirect_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign busy        = busy_q;

    rip_csr_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_mcycle (
        .clk_i   (clk),
        .rst_ni  (rstn),
        .inc_i   (1'b1),
        .wr_lo_i (csr_we && (csr_addr == CSR_MCYCLE)),
        .wr_hi_i (csr_we && (csr_addr == CSR_MCYCLEH)),
        .wdata_i (csr_wdata),
        .value_o (mcycle_val)
    );

    rip_csr_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_minstret (
        .clk_i   (clk),
        .rst_ni  (rstn),
        .inc_i   (retire && !busy_q),
        .wr_lo_i (csr_we && (csr_addr == CSR_MINSTRET)),
        .wr_hi_i (csr_we && (csr_addr == CSR_MINSTRETH)),
        .wdata_i (csr_wdata),
        .value_o (minstret_val)
    );

endmodule

// File: tb/tb_rip_csr_trap_unit.sv
// Scoreboard bench for rip_csr_trap_unit: directed spec scenarios then random traffic.
module tb_rip_csr_trap_unit;

    typedef struct packed {
        logic        csr_valid;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        exc;
        logic [4:0]  cause;
        logic [31:0] epc;
        logic [31:0] tval;
        logic        mret;
        logic        retire;
        logic        irq;
        logic [31:0] ipc;
    } stim_t;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] rdata;
        logic        illegal;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        csr_valid = 1'b0;
    logic [1:0]  csr_op = 2'd0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        exc_valid = 1'b0;
    logic [4:0]  exc_cause = '0;
    logic [31:0] exc_pc = '0;
    logic [31:0] exc_tval = '0;
    logic        mret = 1'b0;
    logic        retire = 1'b0;
    logic        irq_ext = 1'b0;
    logic [31:0] irq_pc = '0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        busy;

    int checks = 0;
    int errors = 0;

    rd_exp_t     rd_q[$];
    logic [31:0] redir_q[$];

    // Reference model state, kept as architectural read values.
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch;
    logic [63:0] m_mcycle, m_minstret;
    bit          m_busy;

    rip_csr_trap_unit #(
        .XLEN        (32),
        .MTVEC_RESET (32'h0000_0000),
        .CNT_WIDTH   (64),
        .VECTORED_EN (1'b1)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .csr_valid   (csr_valid),
        .csr_op      (csr_op),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .exc_valid   (exc_valid),
        .exc_cause   (exc_cause),
        .exc_pc      (exc_pc),
        .exc_tval    (exc_tval),
        .mret        (mret),
        .retire      (retire),
        .irq_ext     (irq_ext),
        .irq_pc      (irq_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic stim_t csr_s(logic [1:0] op, logic [11:0] a, logic [31:0] w);
        stim_t s;
        s = '0;
        s.csr_valid = 1'b1;
        s.op = op;
        s.addr = a;
        s.wdata = w;
        return s;
    endfunction

    task automatic model_reset();
        m_mstatus = 32'h1800;
        m_mie = '0;
        m_mtvec = 32'h0;
        m_mepc = '0;
        m_mcause = '0;
        m_mtval = '0;
        m_mscratch = '0;
        m_mcycle = '0;
        m_minstret = '0;
        m_busy = 1'b0;
    endtask

    task automatic m_read(input logic [11:0] a, input logic irq, output bit known,
                          output logic [31:0] v);
        known = 1'b1;
        case (a)
            12'h300: v = m_mstatus;
            12'h304: v = m_mie;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: v = irq ? 32'h800 : 32'h0;
            12'hB00: v = m_mcycle[31:0];
            12'hB80: v = m_mcycle[63:32];
            12'hB02: v = m_minstret[31:0];
            12'hB82: v = m_minstret[63:32];
            default: begin
                known = 1'b0;
                v = '0;
            end
        endcase
    endtask

    // Predicts this cycle's read and any redirect, then advances to the post-edge state.
    task automatic model_step(input stim_t s, input bit ov_rd, input logic [31:0] rd_val,
                              input bit ov_pc, input logic [31:0] pc_val);
        logic [31:0] old, nv, tgt;
        bit known, wi, ill, exc_t, irq_t, mret_t, we;
        rd_exp_t re;
        m_read(s.addr, s.irq, known, old);
        wi  = (s.op == 2'd1) || (s.op != 2'd0 && s.wdata != 0);
        ill = !known || (s.addr == 12'h344 && wi);
        if (s.csr_valid) begin
            re.addr = s.addr;
            re.rdata = ov_rd ? rd_val : old;
            re.illegal = ill;
            rd_q.push_back(re);
        end
        exc_t  = s.exc && !m_busy;
        irq_t  = s.irq && m_mstatus[3] && m_mie[11] && !m_busy;
        mret_t = s.mret && !m_busy && !exc_t && !irq_t;
        we     = s.csr_valid && wi && !ill && !m_busy && !exc_t && !irq_t && !mret_t;
        nv = (s.op == 2'd1) ? s.wdata : (s.op == 2'd2) ? (old | s.wdata) : (old & ~s.wdata);

        if (we && s.addr == 12'hB00) m_mcycle[31:0] = s.wdata;
        else if (we && s.addr == 12'hB80) m_mcycle[63:32] = s.wdata;
        else m_mcycle = m_mcycle + 1;
        if (we && s.addr == 12'hB02) m_minstret[31:0] = s.wdata;
        else if (we && s.addr == 12'hB82) m_minstret[63:32] = s.wdata;
        else if (s.retire && !m_busy) m_minstret = m_minstret + 1;

        if (exc_t || irq_t) begin
            tgt = m_mtvec & ~32'h3;
            if (!exc_t && m_mtvec[0]) tgt = tgt + 4 * 11;
            m_mepc = (exc_t ? s.epc : s.ipc) & ~32'h3;
            m_mcause = exc_t ? {27'b0, s.cause} : 32'h8000_000B;
            m_mtval = exc_t ? s.tval : 32'h0;
            m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
            redir_q.push_back(ov_pc ? pc_val : tgt);
        end else if (mret_t) begin
            redir_q.push_back(ov_pc ? pc_val : m_mepc);
            m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
        end else if (we) begin
            case (s.addr)
                12'h300: m_mstatus = (nv & 32'h88) | 32'h1800;
                12'h304: m_mie = nv & 32'h800;
                12'h305: m_mtvec = nv & ~32'h2;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~32'h3;
                12'h342: m_mcause = nv;
                12'h343: m_mtval = nv;
                default: ;
            endcase
        end
        m_busy = exc_t || irq_t || mret_t;
    endtask

    task automatic apply(input stim_t s);
        csr_valid = s.csr_valid;
        csr_op = s.op;
        csr_addr = s.addr;
        csr_wdata = s.wdata;
        exc_valid = s.exc;
        exc_cause = s.cause;
        exc_pc = s.epc;
        exc_tval = s.tval;
        mret = s.mret;
        retire = s.retire;
        irq_ext = s.irq;
        irq_pc = s.ipc;
    endtask

    task automatic run(input stim_t s, input bit ov_rd = 1'b0, input logic [31:0] rd_val = 0,
                       input bit ov_pc = 1'b0, input logic [31:0] pc_val = 0);
        rstn = 1'b1;
        apply(s);
        model_step(s, ov_rd, rd_val, ov_pc, pc_val);
        @(posedge clk);
        #1;
    endtask

    task automatic rst_cycle(input stim_t s);
        stim_t t;
        t = s;
        t.csr_valid = 1'b0;
        rstn = 1'b0;
        apply(t);
        model_reset();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a read or a redirect.
    initial begin
        rd_exp_t e;
        logic [31:0] p;
        forever begin
            @(negedge clk);
            if (csr_valid === 1'b1) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL csr_read_unexpected addr=%h got=%h", csr_addr, csr_rdata);
                end else begin
                    e = rd_q.pop_front();
                    if (csr_rdata !== e.rdata || csr_illegal !== e.illegal) begin
                        errors++;
                        $display("FAIL csr_read addr=%h got rdata=%h illegal=%b exp rdata=%h illegal=%b",
                                 e.addr, csr_rdata, csr_illegal, e.rdata, e.illegal);
                    end
                end
            end
            if (redirect === 1'b1) begin
                checks++;
                if (redir_q.size() == 0) begin
                    errors++;
                    $display("FAIL redirect_unexpected got pc=%h", redirect_pc);
                end else begin
                    p = redir_q.pop_front();
                    if (redirect_pc !== p || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL redirect got pc=%h busy=%b exp pc=%h busy=1",
                                 redirect_pc, busy, p);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        logic [11:0] addrs[15];
        addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
                  12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h7C0, 12'h301, 12'hF14};
        model_reset();
        for (int i = 0; i < 3; i++) rst_cycle('0);

        // Counter from reset, then reset values.
        run('0);
        run(csr_s(2'd0, 12'hB00, 0), 1'b1, 32'd1);
        run(csr_s(2'd0, 12'hB00, 0), 1'b1, 32'd2);
        run(csr_s(2'd0, 12'hB00, 0), 1'b1, 32'd3);
        run(csr_s(2'd0, 12'h305, 0), 1'b1, 32'h0);
        run(csr_s(2'd0, 12'h300, 0), 1'b1, 32'h1800);

        // WARL and set/clear.
        run(csr_s(2'd1, 12'h341, 32'h1237), 1'b1, 32'h0);
        run(csr_s(2'd0, 12'h341, 0), 1'b1, 32'h1234);
        run(csr_s(2'd2, 12'h300, 32'h8));
        run(csr_s(2'd0, 12'h300, 0), 1'b1, 32'h1808);
        run(csr_s(2'd3, 12'h300, 32'h8));
        run(csr_s(2'd0, 12'h300, 0), 1'b1, 32'h1800);
        run(csr_s(2'd1, 12'h7C0, 32'h5));
        run(csr_s(2'd1, 12'h344, 32'h800));

        // Synchronous exception.
        run(csr_s(2'd1, 12'h305, 32'h200));
        s = '0; s.exc = 1'b1; s.cause = 5'd2; s.epc = 32'h100; s.tval = 32'hDEAD;
        run(s, 1'b0, 0, 1'b1, 32'h200);
        run('0);
        run(csr_s(2'd0, 12'h341, 0), 1'b1, 32'h100);
        run(csr_s(2'd0, 12'h342, 0), 1'b1, 32'h2);

        // Vectored external interrupt; busy cycle ignores the still-high irq.
        run(csr_s(2'd1, 12'h305, 32'h201));
        run(csr_s(2'd1, 12'h304, 32'h800));
        run(csr_s(2'd2, 12'h300, 32'h8));
        s = '0; s.irq = 1'b1; s.ipc = 32'h300;
        run(s, 1'b0, 0, 1'b1, 32'h22C);
        run(s);
        run(csr_s(2'd0, 12'h342, 0), 1'b1, 32'h8000_000B);
        run(csr_s(2'd0, 12'h300, 0), 1'b1, 32'h1880);

        // mret, then exception colliding with mret.
        s = '0; s.mret = 1'b1;
        run(s, 1'b0, 0, 1'b1, 32'h300);
        run('0);
        run(csr_s(2'd0, 12'h300, 0), 1'b1, 32'h1888);
        s = '0; s.mret = 1'b1; s.exc = 1'b1; s.cause = 5'd3; s.epc = 32'h400;
        run(s, 1'b0, 0, 1'b1, 32'h200);
        run('0);
        run(csr_s(2'd0, 12'h342, 0), 1'b1, 32'h3);

        // Counter carry, and a high-half write during the carry cycle.
        run(csr_s(2'd1, 12'hB00, 32'hFFFF_FFFF));
        run(csr_s(2'd0, 12'hB80, 0), 1'b1, 32'h0);
        run(csr_s(2'd0, 12'hB80, 0), 1'b1, 32'h1);
        run(csr_s(2'd1, 12'hB00, 32'hFFFF_FFFF));
        run(csr_s(2'd1, 12'hB80, 32'h5));
        run(csr_s(2'd0, 12'hB80, 0), 1'b1, 32'h5);

        // Reset in the same cycle as an exception: no redirect may follow.
        s = '0; s.exc = 1'b1; s.cause = 5'd1; s.epc = 32'h800;
        rst_cycle(s);
        run('0);
        run(csr_s(2'd0, 12'h305, 0), 1'b1, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            s = '0;
            s.csr_valid = ($urandom_range(0, 99) < 60);
            s.op = 2'($urandom_range(0, 3));
            s.addr = addrs[$urandom_range(0, 14)];
            s.wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            s.exc = ($urandom_range(0, 99) < 6);
            s.cause = 5'($urandom_range(0, 31));
            s.epc = $urandom;
            s.tval = $urandom;
            s.mret = ($urandom_range(0, 99) < 6);
            s.retire = ($urandom_range(0, 1) == 1);
            s.irq = ($urandom_range(0, 99) < 15);
            s.ipc = $urandom;
            if (i == 1000) rst_cycle(s);
            else run(s);
        end

        for (int i = 0; i < 4; i++) run('0);
        checks++;
        if (rd_q.size() != 0) begin
            errors++;
            $display("FAIL rd_queue_drain got=%0d pending exp=0", rd_q.size());
        end
        checks++;
        if (redir_q.size() != 0) begin
            errors++;
            $display("FAIL redirect_queue_drain got=%0d pending exp=0", redir_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
